dco_bank_ctrl: RTL
==================

// Module: dco_bank_ctrl
// PURPOSE
//  Sequences and configures the DCO capacitor banks (Large/Medium/Small) for the ADPLL.
//  Holds the binary tuning code of each bank, clamps it, and drives the registered
//  row/col/rall matrix encoding, pd and osc_gain of the dco.
//  Steps the DCO through power-up, PVT (L bank), acquisition (M bank) and tracking (S bank).
//  Accepts loop-filter tuning words over a valid/ready handshake with a settle holdoff.
// PARAMETERS
//  STARTUP_CYC  64   cycles pd held low before first tuning write is accepted (>=1)
//  HOLD_CYC     4    cycles tune_ready stays low after each accepted write (0 = no holdoff)
//  L_INIT       12   reset code of L bank (0..25)
//  M_INIT       128  reset code of M bank (0..255)
//  S_INIT       128  reset code of S bank (0..255)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, active-high
//  en            in   1   DCO enable level; 0 forces OFF
//  osc_gain_cfg  in   2   oscillator gain, sampled on OFF->START
//  mode_adv      in   1   one-cycle pulse: advance PVT->ACQ->TRK
//  tune_valid    in   1   tuning word valid
//  tune_word     in   8   unsigned code for the bank selected by state
//  tune_ready    out  1   controller accepts tune_word this cycle
//  state         out  3   0 OFF, 1 START, 2 PVT, 3 ACQ, 4 TRK
//  pd            out  1   DCO power-down
//  osc_gain      out  2   registered oscillator gain
//  c_l_rall/row/col   out  5 each   L bank matrix (5x5)
//  c_m_rall/row/col   out 16 each   M bank matrix (16x16)
//  c_s_rall/row/col   out 16 each   S bank matrix (16x16)
// BEHAVIOUR
//  Reset: state=OFF, pd=1, osc_gain=0, tune_ready=0, codes=L_INIT/M_INIT/S_INIT;
//   matrix outputs already encode the INIT codes on the cycle after rst deasserts.
//  Encoding (width W=5 for L, 16 for M/S), code N: F=N/W, P=N%W;
//   rall[i]=(i<F), row[i]=(i==F), col[j]=(j<P); enabled cells = N exactly.
//   Matrix outputs are registered: 1 cycle after code register update.
//  Clamp: L code = min(tune_word,25); M/S take full 8 bits (0..255).
//  FSM (all transitions on clk, one per cycle):
//   OFF : pd=1. en=1 -> START; osc_gain<=osc_gain_cfg; startup counter cleared.
//   START: pd=0; counts STARTUP_CYC cycles -> PVT. mode_adv ignored.
//   PVT : accepted words load L code. mode_adv -> ACQ.
//   ACQ : accepted words load M code; L frozen. mode_adv -> TRK.
//   TRK : accepted words load S code; L,M frozen. mode_adv ignored.
//   en=0 in any state -> OFF next cycle; pd=1 that cycle; codes retained;
//   a write accepted in that same cycle still completes.
//  Handshake: tune_ready=1 only in PVT/ACQ/TRK with holdoff counter zero and en=1.
//   Transfer when tune_valid&tune_ready; the code register updates the next cycle.
//   The holdoff counter then loads HOLD_CYC; ready stays low for HOLD_CYC cycles.
//   tune_word held across ready-low cycles is not sampled.
//  Simultaneous transfer + mode_adv: word goes to old bank, then state advances.
//   Holdoff continues across the transition.
//  mode_adv during holdoff: advance still taken.
//  rst mid-operation: everything returns to reset values next cycle, incl. counters.
// TESTING
//  T1 rst, en=1, osc_gain_cfg=2 -> pd falls 1 cycle later; state=PVT after 64 cycles; osc_gain=2.
//  T2 PVT, write 30 -> L clamps to 25: c_l_rall=5'b11111, row=0, col=0; 25 cells on.
//  T3 ACQ, write 0x25 (37) -> c_m_rall=0x0003, c_m_row=0x0004, c_m_col=0x001F; L unchanged.
//  T4 TRK, back-to-back valid with HOLD_CYC=4 -> ready low 4 cycles; 2nd word accepted on cycle 5.
//  T5 valid+mode_adv same cycle in PVT, word 7 -> L=7, state ACQ, M unchanged.
//  T6 en=0 in TRK -> pd=1, state=OFF next cycle, codes kept; en=1 -> START with same matrix outputs.

Source files
------------

// File: rtl/dco_bank_ctrl.sv
// rtl/dco_bank_ctrl.sv - DCO capacitor bank sequencer, code clamp and matrix encoder
module dco_bank_ctrl #(
    parameter int STARTUP_CYC = 64,
    parameter int HOLD_CYC    = 4,
    parameter int L_INIT      = 12,
    parameter int M_INIT      = 128,
    parameter int S_INIT      = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  osc_gain_cfg,
    input  logic        mode_adv,
    input  logic        tune_valid,
    input  logic [7:0]  tune_word,
    output logic        tune_ready,
    output logic [2:0]  state,
    output logic        pd,
    output logic [1:0]  osc_gain,
    output logic [4:0]  c_l_rall,
    output logic [4:0]  c_l_row,
    output logic [4:0]  c_l_col,
    output logic [15:0] c_m_rall,
    output logic [15:0] c_m_row,
    output logic [15:0] c_m_col,
    output logic [15:0] c_s_rall,
    output logic [15:0] c_s_row,
    output logic [15:0] c_s_col
);

    localparam int SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
    localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [SW-1:0] START_LAST = SW'(STARTUP_CYC - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYC);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_START = 3'd1,
        ST_PVT   = 3'd2,
        ST_ACQ   = 3'd3,
        ST_TRK   = 3'd4
    } state_t;

    // 5x5 thermometer matrix, packed as {rall, row, col}
    function automatic logic [14:0] enc_l(input logic [4:0] n);
        logic [14:0] m;
        int f;
        int p;
        f = int'(n) / 5;
        p = int'(n) % 5;
        m = '0;
        for (int i = 0; i < 5; i++) begin
            m[10 + i] = (i < f);
            m[5 + i]  = (i == f);
            m[i]      = (i < p);
        end
        return m;
    endfunction

    // 16x16 thermometer matrix, packed as {rall, row, col}
    function automatic logic [47:0] enc_ms(input logic [7:0] n);
        logic [47:0] m;
        int f;
        int p;
        f = int'(n[7:4]);
        p = int'(n[3:0]);
        m = '0;
        for (int i = 0; i < 16; i++) begin
            m[32 + i] = (i < f);
            m[16 + i] = (i == f);
            m[i]      = (i < p);
        end
        return m;
    endfunction

    state_t         st;
    state_t         st_nx;
    logic [SW-1:0]  start_cnt;
    logic [HW-1:0]  hold_cnt;
    logic [HW-1:0]  hold_nx;
    logic           xfer;
    logic [4:0]     code_l;
    logic [7:0]     code_m;
    logic [7:0]     code_s;
    logic [14:0]    l_mat;
    logic [47:0]    m_mat;
    logic [47:0]    s_mat;

    assign xfer  = tune_valid & tune_ready;
    assign state = st;

    // Next state and holdoff count; en low overrides every state
    always_comb begin
        st_nx   = st;
        hold_nx = '0;
        if (!en) begin
            st_nx = ST_OFF;
        end else begin
            case (st)
                ST_OFF:   st_nx = ST_START;
                ST_START: if (start_cnt == START_LAST) st_nx = ST_PVT;
                ST_PVT:   if (mode_adv) st_nx = ST_ACQ;
                ST_ACQ:   if (mode_adv) st_nx = ST_TRK;
                default:  st_nx = st;
            endcase
        end
        if (st_nx == ST_OFF) begin
            hold_nx = '0;
        end else if (xfer) begin
            hold_nx = HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_nx = hold_cnt - 1'b1;
        end
    end

    // Sequencer: state, power-down, gain, counters and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_OFF;
            pd         <= 1'b1;
            osc_gain   <= 2'd0;
            tune_ready <= 1'b0;
            start_cnt  <= '0;
            hold_cnt   <= '0;
        end else begin
            st         <= st_nx;
            pd         <= (st_nx == ST_OFF);
            tune_ready <= (st_nx == ST_PVT || st_nx == ST_ACQ || st_nx == ST_TRK) && (hold_nx == '0);
            hold_cnt   <= hold_nx;
            start_cnt  <= (st == ST_START && st_nx == ST_START) ? start_cnt + 1'b1 : '0;
            if (st == ST_OFF && st_nx == ST_START) begin
                osc_gain <= osc_gain_cfg;
            end
        end
    end

    // Bank code registers load from the bank owned by the current state; matrices follow one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            code_l <= 5'(L_INIT);
            code_m <= 8'(M_INIT);
            code_s <= 8'(S_INIT);
            l_mat  <= enc_l(5'(L_INIT));
            m_mat  <= enc_ms(8'(M_INIT));
            s_mat  <= enc_ms(8'(S_INIT));
        end else begin
            if (xfer) begin
                case (st)
                    ST_PVT:  code_l <= (tune_word > 8'd25) ? 5'd25 : tune_word[4:0];
                    ST_ACQ:  code_m <= tune_word;
                    ST_TRK:  code_s <= tune_word;
                    default: ;
                endcase
            end
            l_mat <= enc_l(code_l);
            m_mat <= enc_ms(code_m);
            s_mat <= enc_ms(code_s);
        end
    end

    assign c_l_rall = l_mat[14:10];
    assign c_l_row  = l_mat[9:5];
    assign c_l_col  = l_mat[4:0];
    assign c_m_rall = m_mat[47:32];
    assign c_m_row  = m_mat[31:16];
    assign c_m_col  = m_mat[15:0];
    assign c_s_rall = s_mat[47:32];
    assign c_s_row  = s_mat[31:16];
    assign c_s_col  = s_mat[15:0];

endmodule
